mux_dataflow_style: RTL and testbench

//   Parameterised N:1 single-bit multiplexer in dataflow style. Default config is 2:1.
//   y = a[s] is purely combinational.
//   The block also provides:
//   - y_q: a one-cycle registered copy of y for timing-clean downstream use.
//   - toggle_cnt: an optional counter of y_q transitions, for debug/activity monitoring.

---
 rtl/mux_dataflow_style.sv | 66 ++++++
 tb/tb_mux_dataflow_style.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_dataflow_style.sv
// mux_dataflow_style: parameterised N:1 single-bit multiplexer.
//   y          - combinational a[s], zero latency, unaffected by clk/rst
//   y_q        - a[s] registered once, cleared by synchronous reset
//   toggle_cnt - saturating count of y_q transitions
// Optional feature macro: MUXDF_TOGGLE_CNT_EN
//   defined   -> the transition counter is built
//   undefined -> no counter logic; toggle_cnt is tied to zero
// The block has no valid/ready handshake and no FSM: every output is valid
// continuously (y) or one clock after its inputs are sampled (y_q, toggle_cnt).
module mux_dataflow_style #(
    parameter int N_IN  = 2,
    parameter int SEL_W = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   a,
    input  logic [SEL_W-1:0]  s,
    output logic              y,
    output logic              y_q,
    output logic [CNT_W-1:0]  toggle_cnt
);

    // Reject configurations where the select cannot address exactly N_IN inputs.
    if ((SEL_W != $clog2(N_IN)) || ((N_IN & (N_IN - 1)) != 0) || (N_IN < 2) || (N_IN > 64))
    begin : g_bad_params
        $error("mux_dataflow_style: N_IN must be a power of two in 2..64 and SEL_W = clog2(N_IN)");
    end

    if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
        $error("mux_dataflow_style: CNT_W must be in 1..32");
    end

    // With N_IN a power of two and SEL_W = clog2(N_IN) every select value is in
    // range, so y is never X for known a and s.
    assign y = a[s];

    // One-cycle registered copy of the selected bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

`ifdef MUXDF_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Count edges where the value about to be loaded into y_q differs from
    // the current y_q; hold at all-ones instead of wrapping. Reset edges never
    // count because the reset branch wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if ((y != y_q) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign toggle_cnt = cnt;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_dataflow_style.sv
// Self-checking bench for mux_dataflow_style.
// Three instances: default 2:1 (CNT_W=8), 2:1 with CNT_W=2 for saturation,
// and 8:1 for wider random select coverage.
module tb_mux_dataflow_style;

`ifdef MUXDF_TOGGLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] a   = '0;
    logic       s   = 1'b0;
    logic [7:0] a8  = '0;
    logic [2:0] s8  = '0;

    logic       y0, yq0, y1, yq1, y2, yq2;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;

    always #5 clk = ~clk;

    mux_dataflow_style dut (
        .clk(clk), .rst(rst), .a(a), .s(s),
        .y(y0), .y_q(yq0), .toggle_cnt(cnt0)
    );

    mux_dataflow_style #(.N_IN(2), .SEL_W(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .s(s),
        .y(y1), .y_q(yq1), .toggle_cnt(cnt1)
    );

    mux_dataflow_style #(.N_IN(8), .SEL_W(3), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .s(s8),
        .y(y2), .y_q(yq2), .toggle_cnt(cnt2)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Selected bit = bit s of a, taken arithmetically; y_q is the last sampled
    // selection; the counter is an integer capped at its instance's maximum.
    int m_yq  [3];
    int m_cnt [3];
    int m_max [3];

    function automatic int pick(input int av, input int sv);
        return (av >> sv) & 1;
    endfunction

    task automatic model_edge(input int idx, input int r, input int av, input int sv);
        int nv;
        if (r != 0) begin
            m_yq[idx]  = 0;
            m_cnt[idx] = 0;
        end else begin
            nv = pick(av, sv);
            if (CNT_EN && (nv != m_yq[idx]) && (m_cnt[idx] < m_max[idx])) m_cnt[idx]++;
            m_yq[idx] = nv;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_y0"},   32'(y0),   32'(pick(a, s)));
        check({tag, "_y1"},   32'(y1),   32'(pick(a, s)));
        check({tag, "_y8"},   32'(y2),   32'(pick(a8, s8)));
        check({tag, "_yq0"},  32'(yq0),  32'(m_yq[0]));
        check({tag, "_yq1"},  32'(yq1),  32'(m_yq[1]));
        check({tag, "_yq8"},  32'(yq2),  32'(m_yq[2]));
        check({tag, "_cnt0"}, 32'(cnt0), 32'(m_cnt[0]));
        check({tag, "_cnt1"}, 32'(cnt1), 32'(m_cnt[1]));
        check({tag, "_cnt8"}, 32'(cnt2), 32'(m_cnt[2]));
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, let the rising edge sample, compare 1ns later.
    task automatic step(input logic r, input logic [1:0] av, input logic sv,
                        input logic [7:0] a8v, input logic [2:0] s8v, input string tag);
        @(negedge clk);
        rst = r; a = av; s = sv; a8 = a8v; s8 = s8v;
        @(posedge clk);
        #1;
        model_edge(0, int'(r), int'(av),  int'(sv));
        model_edge(1, int'(r), int'(av),  int'(sv));
        model_edge(2, int'(r), int'(a8v), int'(s8v));
        check_all(tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] a;
        logic       s;
        logic       y;
    } vec_t;

    vec_t vecs[8];

    initial begin
        m_yq  = '{0, 0, 0};
        m_cnt = '{0, 0, 0};
        m_max = '{255, 3, 255};

        // s=0 -> y=a[0]; s=1 -> y=a[1]
        vecs[0] = '{2'b00, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 1'b0, 1'b1};
        vecs[2] = '{2'b10, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 1'b0, 1'b1};
        vecs[4] = '{2'b00, 1'b1, 1'b0};
        vecs[5] = '{2'b01, 1'b1, 1'b0};
        vecs[6] = '{2'b10, 1'b1, 1'b1};
        vecs[7] = '{2'b11, 1'b1, 1'b1};

        // Reset state after two reset edges.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_yq",  32'(yq0),  32'd0);
        check("reset_cnt", 32'(cnt0), 32'd0);

        // Combinational sweep every 5ns while reset holds y_q/count at zero:
        // y must follow inputs even during reset.
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a;
            s = vecs[i].s;
            #5;
            check($sformatf("tbl_y_%0d", i), 32'(y0), 32'(vecs[i].y));
            check($sformatf("tbl_yq_%0d", i), 32'(yq0), 32'd0);
        end

        // Reset for two cycles with a=10,s=1, then release.
        step(1'b1, 2'b10, 1'b1, 8'h00, 3'd0, "rst3_a");
        step(1'b1, 2'b10, 1'b1, 8'h00, 3'd0, "rst3_b");
        check("rst3_yq_held", 32'(yq0), 32'd0);
        step(1'b0, 2'b10, 1'b1, 8'h00, 3'd0, "rst3_rel");
        check("rst3_yq_after", 32'(yq0), 32'd1);

        // Ten toggles from a cleared state; CNT_W=2 instance saturates at 3.
        step(1'b1, 2'b00, 1'b0, 8'h00, 3'd0, "tog_rst");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i % 2 == 0) ? 2'b01 : 2'b00, 1'b0, 8'h00, 3'd0, "tog");
        end
        check("tog_cnt10", 32'(cnt0), CNT_EN ? 32'd10 : 32'd0);
        check("tog_sat3",  32'(cnt1), CNT_EN ? 32'd3  : 32'd0);

        // Reset mid-count, then counting resumes on the first free edge.
        step(1'b0, 2'b01, 1'b0, 8'h00, 3'd0, "mid_pre");
        step(1'b1, 2'b01, 1'b0, 8'h00, 3'd0, "mid_rst");
        check("mid_cnt_clr", 32'(cnt0), 32'd0);
        check("mid_yq_clr",  32'(yq0),  32'd0);
        step(1'b0, 2'b01, 1'b0, 8'h00, 3'd0, "mid_resume");
        check("mid_cnt_resume", 32'(cnt0), CNT_EN ? 32'd1 : 32'd0);

        // Randomised stimulus with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
